kf_au_arbiter: RTL and testbench

//  Shares the single kf arithmetic unit (au) between NREQ requesters, e.g. the sequencer and a host/debug port.

---
 rtl/kf_au_arbiter_if.sv | 34 +++
 rtl/kf_au_arbiter.sv | 147 ++++++++++++++
 tb/tb_kf_au_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kf_au_arbiter_if.sv
// Bus bundle between the kf AU arbiter, its requesters and the shared arithmetic unit.
// Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i]; rsp_valid is a 1-cycle pulse, no back-pressure.
interface kf_au_arbiter_if #(
    parameter int W    = 24,
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_r;
    logic [W*NREQ-1:0] req_s;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic              au_start;
    logic [W-1:0]      au_r;
    logic [W-1:0]      au_s;
    logic [1:0]        au_op;
    logic [W-1:0]      au_result;
    logic              au_done;
    logic              busy;
    logic [IDW-1:0]    owner;

    modport master (
        output req_valid, req_op, req_r, req_s, au_result, au_done,
        input  req_ready, rsp_valid, rsp_data, rsp_err, au_start, au_r, au_s, au_op, busy, owner
    );

    modport slave (
        input  req_valid, req_op, req_r, req_s, au_result, au_done,
        output req_ready, rsp_valid, rsp_data, rsp_err, au_start, au_r, au_s, au_op, busy, owner
    );
endinterface

// File: rtl/kf_au_arbiter.sv
// Round-robin arbiter sharing one kf arithmetic unit between NREQ requesters,
// one op in flight, with a watchdog that aborts ops whose AU done never arrives.
module kf_au_arbiter #(
    parameter int W    = 24,
    parameter int NREQ = 2,
    parameter int TMO  = 64,
    parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    kf_au_arbiter_if.slave bus,
    output logic [1:0]     dbg_state_o
);
    localparam int CW = $clog2(TMO);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    r_q, r_d;
    logic [W-1:0]    s_q, s_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic [IDW-1:0]  grant_id, grant_nxt;
    logic [1:0]      sel_op;
    logic [W-1:0]    sel_r, sel_s;
    int              idx;

    // First valid requester scanning upward from the pointer, wrapping at NREQ.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        grant_nxt = '0;
        sel_op    = '0;
        sel_r     = '0;
        sel_s     = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_any && bus.req_valid[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
                grant_nxt  = (idx == NREQ - 1) ? '0 : IDW'(idx + 1);
                sel_op     = bus.req_op[2*idx +: 2];
                sel_r      = bus.req_r[W*idx +: W];
                sel_s      = bus.req_s[W*idx +: W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        r_d         = r_q;
        s_d         = s_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    op_d    = sel_op;
                    r_d     = sel_r;
                    s_d     = sel_s;
                    owner_d = grant_id;
                    ptr_d   = grant_nxt;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A done arriving on the last allowed cycle still counts as success.
                if (bus.au_done) begin
                    rsp_valid_d = NREQ'(1) << owner_q;
                    rsp_data_d  = bus.au_result;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    rsp_valid_d = NREQ'(1) << owner_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            r_q         <= '0;
            s_q         <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            r_q         <= r_d;
            s_q         <= s_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE) ? grant : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.au_start  = (state_q == ISSUE);
    assign bus.au_r      = r_q;
    assign bus.au_s      = s_q;
    assign bus.au_op     = op_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.owner     = owner_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_kf_au_arbiter.sv
// Bench for kf_au_arbiter: drives requesters and plays the AU by hand, checking grants,
// AU issue, timeouts, reset and stray done pulses against a response queue.
module tb_kf_au_arbiter;
    localparam int W    = 24;
    localparam int NREQ = 2;
    localparam int TMO  = 8;
    localparam int IDW  = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] dbg_state;
    int total = 0;
    int bad = 0;
    logic [NREQ+W:0] exp_q[$];
    logic [NREQ+W:0] mexp;

    kf_au_arbiter_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus();

    kf_au_arbiter #(.W(W), .NREQ(NREQ), .TMO(TMO), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Response scoreboard: every rsp_valid pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (bus.rsp_valid !== '0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got valid=%b err=%b data=%h, required no response",
                         bus.rsp_valid, bus.rsp_err, bus.rsp_data);
            end else begin
                mexp = exp_q.pop_front();
                if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== mexp) begin
                    bad++;
                    $display("FAIL rsp_scoreboard: got valid=%b err=%b data=%h, required valid=%b err=%b data=%h",
                             bus.rsp_valid, bus.rsp_err, bus.rsp_data,
                             mexp[NREQ+W:W+1], mexp[W], mexp[W-1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_r     = '0;
        bus.req_s     = '0;
        bus.au_result = '0;
        bus.au_done   = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        total++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.au_start, bus.busy, bus.owner} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: got ready=%b rsp=%b err=%b start=%b busy=%b owner=%0d, required all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.au_start, bus.busy, bus.owner);
        end
        total++;
        if ({bus.rsp_data, bus.au_r, bus.au_s, bus.au_op, dbg_state} !== '0) begin
            bad++;
            $display("FAIL reset_data: got data=%h r=%h s=%h op=%b state=%0d, required all 0",
                     bus.rsp_data, bus.au_r, bus.au_s, bus.au_op, dbg_state);
        end
        bus.req_valid = 2'b11;
        #1;
        total++;
        if (bus.req_ready !== 2'b01) begin
            bad++;
            $display("FAIL reset_pointer: got ready=%b, required 01", bus.req_ready);
        end
        bus.req_valid = '0;
        step();
    endtask

    task automatic test_single_mul();
        bus.req_op    = {2'b00, 2'b10};
        bus.req_r     = {24'h0, 24'h004000};
        bus.req_s     = {24'h0, 24'h008000};
        bus.req_valid = 2'b01;
        #1;
        total++;
        if (bus.req_ready !== 2'b01) begin
            bad++;
            $display("FAIL mul_grant: got ready=%b, required 01", bus.req_ready);
        end
        exp_q.push_back({2'b01, 1'b0, 24'h002000});
        step();
        bus.req_valid = '0;
        total++;
        if ({bus.au_start, bus.au_op, bus.au_r, bus.au_s, bus.owner, bus.busy}
            !== {1'b1, 2'b10, 24'h004000, 24'h008000, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL mul_issue: got start=%b op=%b r=%h s=%h owner=%0d busy=%b, required 1 10 004000 008000 0 1",
                     bus.au_start, bus.au_op, bus.au_r, bus.au_s, bus.owner, bus.busy);
        end
        step();
        total++;
        if (bus.au_start !== 1'b0 || dbg_state !== 2'd2) begin
            bad++;
            $display("FAIL mul_start_pulse: got start=%b state=%0d, required 0 and 2", bus.au_start, dbg_state);
        end
        repeat (2) step();
        bus.au_done   = 1'b1;
        bus.au_result = 24'h002000;
        step();
        bus.au_done = 1'b0;
        total++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {2'b01, 1'b0, 24'h002000}) begin
            bad++;
            $display("FAIL mul_latency: got rsp=%b err=%b data=%h at t5, required 01 0 002000",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_data);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ra[NREQ];
        logic [W-1:0] sa[NREQ];
        logic [W-1:0] res;
        logic [1:0]   exp_g;
        int id;
        int lat;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bus.req_op    = '0;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            id    = k % 2;
            exp_g = (id == 0) ? 2'b01 : 2'b10;
            for (int j = 0; j < NREQ; j++) begin
                ra[j] = W'($urandom);
                sa[j] = W'($urandom);
            end
            bus.req_r = {ra[1], ra[0]};
            bus.req_s = {sa[1], sa[0]};
            #1;
            total++;
            if (bus.req_ready !== exp_g) begin
                bad++;
                $display("FAIL rr_grant[%0d]: got ready=%b, required %b", k, bus.req_ready, exp_g);
            end
            res = ra[id] + sa[id];
            exp_q.push_back({exp_g, 1'b0, res});
            lat = $urandom_range(1, 5);
            step();
            total++;
            if ({bus.au_start, bus.req_ready, bus.owner, bus.au_op, bus.au_r, bus.au_s}
                !== {1'b1, 2'b00, IDW'(id), 2'b00, ra[id], sa[id]}) begin
                bad++;
                $display("FAIL rr_issue[%0d]: got start=%b ready=%b owner=%0d op=%b r=%h s=%h, required 1 00 %0d 00 %h %h",
                         k, bus.au_start, bus.req_ready, bus.owner, bus.au_op, bus.au_r, bus.au_s, id, ra[id], sa[id]);
            end
            repeat (lat) step();
            bus.au_done   = 1'b1;
            bus.au_result = res;
            step();
            bus.au_done = 1'b0;
            total++;
            if (bus.rsp_valid !== exp_g) begin
                bad++;
                $display("FAIL rr_rsp[%0d]: got rsp=%b, required %b", k, bus.rsp_valid, exp_g);
            end
        end
        bus.req_valid = '0;
        step();
    endtask

    task automatic test_timeout();
        logic [W-1:0] a, b, res;
        bus.req_op    = {2'b11, 2'b00};
        bus.req_r     = {W'($urandom), W'($urandom)};
        bus.req_s     = {W'($urandom), W'($urandom)};
        bus.req_valid = 2'b10;
        #1;
        total++;
        if (bus.req_ready !== 2'b10) begin
            bad++;
            $display("FAIL tmo_grant: got ready=%b, required 10", bus.req_ready);
        end
        exp_q.push_back({2'b10, 1'b1, {W{1'b0}}});
        step();
        bus.req_valid = '0;
        step();
        repeat (TMO - 1) step();
        total++;
        if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b1 || dbg_state !== 2'd2) begin
            bad++;
            $display("FAIL tmo_early: got rsp=%b busy=%b state=%0d on WAIT cycle %0d, required 00 1 2",
                     bus.rsp_valid, bus.busy, dbg_state, TMO);
        end
        step();
        total++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.busy} !== {2'b10, 1'b1, {W{1'b0}}, 1'b0}) begin
            bad++;
            $display("FAIL tmo_abort: got rsp=%b err=%b data=%h busy=%b, required 10 1 000000 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.busy);
        end
        a = W'($urandom);
        b = W'($urandom);
        res = a + b;
        bus.req_op    = '0;
        bus.req_r     = {W'(0), a};
        bus.req_s     = {W'(0), b};
        bus.req_valid = 2'b01;
        #1;
        total++;
        if (bus.req_ready !== 2'b01) begin
            bad++;
            $display("FAIL tmo_next_grant: got ready=%b, required 01", bus.req_ready);
        end
        exp_q.push_back({2'b01, 1'b0, res});
        step();
        bus.req_valid = '0;
        step();
        bus.au_done   = 1'b1;
        bus.au_result = res;
        step();
        bus.au_done = 1'b0;
        total++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {2'b01, 1'b0, res}) begin
            bad++;
            $display("FAIL tmo_next_rsp: got rsp=%b err=%b data=%h, required 01 0 %h",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_data, res);
        end
        step();
    endtask

    task automatic test_done_at_limit();
        logic [W-1:0] a, b, res;
        a = W'($urandom);
        b = W'($urandom);
        res = a - b;
        bus.req_op    = {2'b00, 2'b01};
        bus.req_r     = {W'(0), a};
        bus.req_s     = {W'(0), b};
        bus.req_valid = 2'b01;
        #1;
        exp_q.push_back({2'b01, 1'b0, res});
        step();
        bus.req_valid = '0;
        step();
        repeat (TMO - 1) step();
        bus.au_done   = 1'b1;
        bus.au_result = res;
        step();
        bus.au_done = 1'b0;
        total++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {2'b01, 1'b0, res}) begin
            bad++;
            $display("FAIL limit_done: got rsp=%b err=%b data=%h, required 01 0 %h",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_data, res);
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] a, b, res;
        bus.req_op    = {2'b00, 2'b10};
        bus.req_r     = {W'($urandom), W'($urandom)};
        bus.req_s     = {W'($urandom), W'($urandom)};
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = '0;
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.au_start, bus.busy, bus.owner, bus.au_op, dbg_state} !== '0) begin
            bad++;
            $display("FAIL rst_mid_ctrl: got ready=%b rsp=%b err=%b start=%b busy=%b owner=%0d op=%b state=%0d, required all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.au_start, bus.busy, bus.owner, bus.au_op, dbg_state);
        end
        total++;
        if ({bus.rsp_data, bus.au_r, bus.au_s} !== '0) begin
            bad++;
            $display("FAIL rst_mid_data: got data=%h r=%h s=%h, required all 0", bus.rsp_data, bus.au_r, bus.au_s);
        end
        repeat (2) step();
        rst_n = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        res = a ^ b;
        bus.req_r     = {b, a};
        bus.req_s     = {a, b};
        bus.req_op    = '0;
        bus.req_valid = 2'b11;
        #1;
        total++;
        if (bus.req_ready !== 2'b01) begin
            bad++;
            $display("FAIL rst_mid_regrant: got ready=%b, required 01", bus.req_ready);
        end
        exp_q.push_back({2'b01, 1'b0, res});
        step();
        bus.req_valid = '0;
        step();
        step();
        bus.au_done   = 1'b1;
        bus.au_result = res;
        step();
        bus.au_done = 1'b0;
        total++;
        if ({bus.rsp_valid, bus.rsp_data} !== {2'b01, res}) begin
            bad++;
            $display("FAIL rst_mid_rsp: got rsp=%b data=%h, required 01 %h", bus.rsp_valid, bus.rsp_data, res);
        end
        step();
    endtask

    task automatic test_spurious_done();
        logic [W-1:0] res;
        res = W'($urandom) | W'(1);
        bus.au_done   = 1'b1;
        bus.au_result = ~res;
        step();
        bus.au_done = 1'b0;
        total++;
        if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL stray_idle: got rsp=%b busy=%b state=%0d, required 00 0 0", bus.rsp_valid, bus.busy, dbg_state);
        end
        bus.req_op    = {2'b11, 2'b00};
        bus.req_valid = 2'b10;
        bus.au_done   = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 2'b10) begin
            bad++;
            $display("FAIL stray_grant: got ready=%b, required 10", bus.req_ready);
        end
        exp_q.push_back({2'b10, 1'b0, res});
        step();
        bus.req_valid = '0;
        total++;
        if (bus.au_start !== 1'b1 || dbg_state !== 2'd1) begin
            bad++;
            $display("FAIL stray_issue: got start=%b state=%0d, required 1 1", bus.au_start, dbg_state);
        end
        step();
        bus.au_done = 1'b0;
        total++;
        if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b1 || dbg_state !== 2'd2) begin
            bad++;
            $display("FAIL stray_wait: got rsp=%b busy=%b state=%0d, required 00 1 2", bus.rsp_valid, bus.busy, dbg_state);
        end
        step();
        bus.au_done   = 1'b1;
        bus.au_result = res;
        step();
        bus.au_done = 1'b0;
        total++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {2'b10, 1'b0, res}) begin
            bad++;
            $display("FAIL stray_real_done: got rsp=%b err=%b data=%h, required 10 0 %h",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_data, res);
        end
        step();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_r     = '0;
        bus.req_s     = '0;
        bus.au_result = '0;
        bus.au_done   = 1'b0;
        test_reset();
        test_single_mul();
        test_back_to_back();
        test_timeout();
        test_done_at_limit();
        test_reset_mid_op();
        test_spurious_done();
        repeat (3) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rsp_missing: got %0d responses still pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
